// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, select width, sequencer states and decode helpers.
// Used by the sequencer and by the ALU testbenches.
package alu_pkg;

    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned ALU_SEL_W = 12;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHR = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHL = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ROR = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ROL = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_DIV = 4'h9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NEG = 4'hA;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOT = 4'hB;

    // StDivErr is only reachable when the divide-by-zero check is built in.
    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDivErr
    } seq_state_e;

    function automatic logic alu_is_legal(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_OP_NOT;
    endfunction

    function automatic logic [ALU_SEL_W-1:0] alu_onehot(input logic [ALU_OP_W-1:0] op);
        logic [ALU_SEL_W-1:0] one;
        one = {{(ALU_SEL_W-1){1'b0}}, 1'b1};
        return alu_is_legal(op) ? (one << op) : '0;
    endfunction

    function automatic logic alu_is_hilo(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle between the control unit / ALU datapath (master) and the alu_sequencer (slave).
interface alu_sequencer_if;
    import alu_pkg::*;

    logic                 start;
    logic [ALU_OP_W-1:0]  opcode;
    logic [31:0]          a_in;
    logic [31:0]          b_in;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [31:0]          z_out;
    logic [31:0]          hi_out;
    logic [31:0]          lo_out;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [ALU_SEL_W-1:0] alu_select;
    logic [31:0]          alu_z;
    logic [31:0]          alu_hi;
    logic [31:0]          alu_lo;

    modport master (
        output start, opcode, a_in, b_in, alu_z, alu_hi, alu_lo,
        input  busy, done, err, z_out, hi_out, lo_out, alu_a, alu_b, alu_select
    );

    modport slave (
        input  start, opcode, a_in, b_in, alu_z, alu_hi, alu_lo,
        output busy, done, err, z_out, hi_out, lo_out, alu_a, alu_b, alu_select
    );

endinterface

// File: rtl/alu_latency_counter.sv
// Loadable down-counter that times the EXEC phase; holds at zero once expired.
module alu_latency_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle start/done controller in front of the ALU datapath.
// Optional build macro: ALU_SEQ_DIV0_CHECK_EN rejects divide-by-zero without running the divider.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 33
) (
    input logic             clk,
    input logic             rst_n,
    alu_sequencer_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    seq_state_e          state_q, state_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [31:0]         a_q, a_d, b_q, b_d;
    logic [31:0]         z_q, z_d, hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d, err_q, err_d;
    logic                cnt_load, cnt_zero, div0;
    logic [CNT_W-1:0]    cnt_val;

`ifdef ALU_SEQ_DIV0_CHECK_EN
    assign div0 = (bus.opcode == ALU_OP_DIV) && (bus.b_in == '0);
`else
    assign div0 = 1'b0;
`endif

    // Counter is loaded with latency-1 so that it reads zero in the last EXEC cycle.
    always_comb begin
        cnt_val = '0;
        if (bus.opcode == ALU_OP_MUL) begin
            cnt_val = CNT_W'(MUL_CYCLES - 1);
        end else if (bus.opcode == ALU_OP_DIV) begin
            cnt_val = CNT_W'(DIV_CYCLES - 1);
        end
    end

    alu_latency_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_load = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (!alu_is_legal(bus.opcode)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        op_d    = bus.opcode;
                        a_d     = bus.a_in;
                        b_d     = bus.b_in;
                        if (div0) begin
                            state_d = StDivErr;
                        end else begin
                            cnt_load = 1'b1;
                            state_d  = StExec;
                        end
                    end
                end
            end
            StExec: begin
                if (cnt_zero) begin
                    if (alu_is_hilo(op_q)) begin
                        hi_d = bus.alu_hi;
                        lo_d = bus.alu_lo;
                    end else begin
                        z_d = bus.alu_z;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StDivErr: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.z_out      = z_q;
    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_select = (state_q == StExec) ? alu_onehot(op_q) : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU environment, directed scenarios and
// randomized back-to-back traffic checked against a latency/result reference model.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned MUL_C = 2;
    localparam int unsigned DIV_C = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer #(
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_z, exp_hi, exp_lo;

    // Arithmetic of the ALU itself; returns {hi, lo, z}.
    function automatic logic [95:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] w;
        logic [31:0] z, hi, lo;
        z = '0; hi = '0; lo = '0;
        w = {a, a};
        case (op)
            4'h0: z = a + b;
            4'h1: z = a - b;
            4'h2: z = a >> b[4:0];
            4'h3: z = a << b[4:0];
            4'h4: begin w = w >> b[4:0]; z = w[31:0]; end
            4'h5: begin w = w << b[4:0]; z = w[63:32]; end
            4'h6: z = a & b;
            4'h7: z = a | b;
            4'h8: begin w = {32'd0, a} * {32'd0, b}; hi = w[63:32]; lo = w[31:0]; end
            4'h9: begin
                if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            4'hA: z = -b;
            4'hB: z = ~b;
            default: z = 32'hDEAD_BEEF;
        endcase
        return {hi, lo, z};
    endfunction

    logic [95:0] env_r;
    always_comb begin
        env_r = {3{32'hDEAD_BEEF}};
        for (int i = 0; i < 12; i++) begin
            if (bus.alu_select == (12'd1 << i)) env_r = alu_fn(4'(i), bus.alu_a, bus.alu_b);
        end
    end
    assign bus.alu_z  = env_r[31:0];
    assign bus.alu_lo = env_r[63:32];
    assign bus.alu_hi = env_r[95:64];

    int   o_done_k, o_done_cnt, o_busy_cnt, o_sel_bad, o_err_stray;
    logic o_err;

    task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.a_in   = a;
        bus.b_in   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Observes k = 1..budget cycles after the start edge (negedge sampling).
    task automatic watch(input int budget, input bit stop_on_done, input logic [11:0] exp_sel);
        o_done_k = 0; o_done_cnt = 0; o_busy_cnt = 0; o_sel_bad = 0; o_err_stray = 0; o_err = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) o_busy_cnt++;
            if ((bus.busy === 1'b1 && bus.alu_select !== exp_sel) ||
                (bus.busy !== 1'b1 && bus.alu_select !== 12'd0)) o_sel_bad++;
            if (bus.done === 1'b1) begin
                o_done_cnt++;
                if (o_done_k == 0) begin
                    o_done_k = k;
                    o_err    = bus.err;
                end
                if (stop_on_done) break;
            end else if (bus.err !== 1'b0) begin
                o_err_stray++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.opcode = '0; bus.a_in = '0; bus.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.err});
        end
        n_tests++;
        if (bus.alu_select !== 12'd0) begin
            n_fail++; $display("FAIL reset_select got %h want 000", bus.alu_select);
        end
        n_tests++;
        if ({bus.alu_a, bus.alu_b, bus.z_out, bus.hi_out, bus.lo_out} !== 160'd0) begin
            n_fail++; $display("FAIL reset_regs got a=%h b=%h z=%h hi=%h lo=%h want all 0",
                               bus.alu_a, bus.alu_b, bus.z_out, bus.hi_out, bus.lo_out);
        end
        exp_z = '0; exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        drive_start(ALU_OP_ADD, 32'h7C, 32'h7);
        watch(5, 1'b0, 12'h001);
        exp_z = 32'd131;
        n_tests++;
        if (o_done_k != 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", o_done_k); end
        n_tests++;
        if (o_done_cnt != 1 || o_busy_cnt != 1) begin
            n_fail++; $display("FAIL add_pulse got done=%0d busy=%0d want 1 1", o_done_cnt, o_busy_cnt);
        end
        n_tests++;
        if (o_sel_bad != 0 || o_err !== 1'b0 || o_err_stray != 0) begin
            n_fail++; $display("FAIL add_sel_err got selbad=%0d err=%b stray=%0d want 0 0 0",
                               o_sel_bad, o_err, o_err_stray);
        end
        n_tests++;
        if (bus.z_out !== exp_z || bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) begin
            n_fail++; $display("FAIL add_result got z=%h hi=%h lo=%h want %h %h %h",
                               bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mul();
        drive_start(ALU_OP_MUL, 32'd124, 32'd7);
        watch(6, 1'b0, 12'h100);
        exp_hi = 32'd0; exp_lo = 32'd868;
        n_tests++;
        if (o_done_k != 3 || o_busy_cnt != 2) begin
            n_fail++; $display("FAIL mul_latency got done_k=%0d busy=%0d want 3 2", o_done_k, o_busy_cnt);
        end
        n_tests++;
        if (o_sel_bad != 0 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL mul_sel_err got selbad=%0d err=%b want 0 0", o_sel_bad, o_err);
        end
        n_tests++;
        if (bus.lo_out !== exp_lo || bus.hi_out !== exp_hi || bus.z_out !== exp_z) begin
            n_fail++; $display("FAIL mul_result got z=%h hi=%h lo=%h want %h %h %h",
                               bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
        end
    endtask

    task automatic test_start_while_busy();
        drive_start(ALU_OP_DIV, 32'd100, 32'd7);
        fork
            begin
                repeat (3) @(negedge clk);
                bus.start = 1'b1; bus.opcode = ALU_OP_ADD; bus.a_in = 32'd5; bus.b_in = 32'd5;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join_none
        watch(DIV_C + 6, 1'b0, 12'h200);
        exp_lo = 32'd14; exp_hi = 32'd2;
        n_tests++;
        if (o_done_k != DIV_C + 1 || o_done_cnt != 1 || o_busy_cnt != DIV_C) begin
            n_fail++; $display("FAIL busy_ignore_timing got done_k=%0d done=%0d busy=%0d want %0d 1 %0d",
                               o_done_k, o_done_cnt, o_busy_cnt, DIV_C + 1, DIV_C);
        end
        n_tests++;
        if (o_sel_bad != 0 || bus.alu_a !== 32'd100 || bus.alu_b !== 32'd7) begin
            n_fail++; $display("FAIL busy_ignore_latch got selbad=%0d a=%h b=%h want 0 64 7",
                               o_sel_bad, bus.alu_a, bus.alu_b);
        end
        n_tests++;
        if (bus.lo_out !== exp_lo || bus.hi_out !== exp_hi || bus.z_out !== exp_z) begin
            n_fail++; $display("FAIL busy_ignore_result got z=%h hi=%h lo=%h want %h %h %h",
                               bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
        end
    endtask

    task automatic test_illegal_back_to_back();
        drive_start(4'hD, $urandom, $urandom);
        watch(4, 1'b1, 12'h000);
        n_tests++;
        if (o_done_k != 1 || o_err !== 1'b1 || o_busy_cnt != 0) begin
            n_fail++; $display("FAIL illegal got done_k=%0d err=%b busy=%0d want 1 1 0",
                               o_done_k, o_err, o_busy_cnt);
        end
        n_tests++;
        if (bus.alu_a !== 32'd100 || bus.z_out !== exp_z || bus.hi_out !== exp_hi ||
            bus.lo_out !== exp_lo) begin
            n_fail++; $display("FAIL illegal_regs got a=%h z=%h hi=%h lo=%h want 64 %h %h %h",
                               bus.alu_a, bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
        end
        drive_start(ALU_OP_NEG, 32'd0, 32'd7);
        watch(4, 1'b1, 12'h400);
        exp_z = 32'hFFFF_FFF9;
        n_tests++;
        if (o_done_k != 2 || o_err !== 1'b0 || bus.z_out !== exp_z) begin
            n_fail++; $display("FAIL b2b_neg got done_k=%0d err=%b z=%h want 2 0 %h",
                               o_done_k, o_err, bus.z_out, exp_z);
        end
    endtask

    task automatic test_reset_mid_op();
        drive_start(ALU_OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tests++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.alu_select !== 12'd0 ||
            {bus.alu_a, bus.alu_b, bus.z_out, bus.hi_out, bus.lo_out} !== 160'd0) begin
            n_fail++; $display("FAIL midreset_outputs got busy=%b done=%b sel=%h a=%h z=%h lo=%h want 0",
                               bus.busy, bus.done, bus.alu_select, bus.alu_a, bus.z_out, bus.lo_out);
        end
        exp_z = '0; exp_hi = '0; exp_lo = '0;
        watch(DIV_C + 3, 1'b0, 12'h000);
        n_tests++;
        if (o_done_cnt != 0 || o_busy_cnt != 0) begin
            n_fail++; $display("FAIL midreset_no_done got done=%0d busy=%0d want 0 0",
                               o_done_cnt, o_busy_cnt);
        end
    endtask

    task automatic test_div_zero();
        logic [95:0] r;
        drive_start(ALU_OP_MUL, 32'h1234_5678, 32'h10);
        watch(6, 1'b1, 12'h100);
        exp_hi = 32'h1; exp_lo = 32'h2345_6780;
        n_tests++;
        if (bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) begin
            n_fail++; $display("FAIL div0_setup got hi=%h lo=%h want %h %h",
                               bus.hi_out, bus.lo_out, exp_hi, exp_lo);
        end
        drive_start(ALU_OP_DIV, 32'd55, 32'd0);
`ifdef ALU_SEQ_DIV0_CHECK_EN
        watch(DIV_C + 4, 1'b0, 12'h000);
        n_tests++;
        if (o_done_k != 2 || o_err !== 1'b1 || o_busy_cnt != 1 || o_done_cnt != 1) begin
            n_fail++; $display("FAIL div0_check got done_k=%0d err=%b busy=%0d done=%0d want 2 1 1 1",
                               o_done_k, o_err, o_busy_cnt, o_done_cnt);
        end
`else
        watch(DIV_C + 4, 1'b0, 12'h200);
        r = alu_fn(ALU_OP_DIV, 32'd55, 32'd0);
        exp_hi = r[95:64]; exp_lo = r[63:32];
        n_tests++;
        if (o_done_k != DIV_C + 1 || o_err !== 1'b0 || o_busy_cnt != DIV_C) begin
            n_fail++; $display("FAIL div0_nocheck got done_k=%0d err=%b busy=%0d want %0d 0 %0d",
                               o_done_k, o_err, o_busy_cnt, DIV_C + 1, DIV_C);
        end
`endif
        n_tests++;
        if (bus.hi_out !== exp_hi || bus.lo_out !== exp_lo || bus.z_out !== exp_z) begin
            n_fail++; $display("FAIL div0_regs got z=%h hi=%h lo=%h want %h %h %h",
                               bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [95:0] r;
        int          lat, exp_k, exp_busy;
        logic        exp_err;
        logic [11:0] exp_sel;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            lat = (op == 4'h8) ? MUL_C : (op == 4'h9) ? DIV_C : 1;
            if (op > 4'hB) begin
                exp_k = 1; exp_busy = 0; exp_err = 1'b1; exp_sel = 12'h000;
`ifdef ALU_SEQ_DIV0_CHECK_EN
            end else if (op == 4'h9 && b == 0) begin
                exp_k = 2; exp_busy = 1; exp_err = 1'b1; exp_sel = 12'h000;
`endif
            end else begin
                exp_k = lat + 1; exp_busy = lat; exp_err = 1'b0; exp_sel = 12'd1 << op;
                r = alu_fn(op, a, b);
                if (op == 4'h8 || op == 4'h9) begin
                    exp_hi = r[95:64]; exp_lo = r[63:32];
                end else begin
                    exp_z = r[31:0];
                end
            end
            drive_start(op, a, b);
            watch(DIV_C + 4, 1'b1, exp_sel);
            n_tests++;
            if (o_done_k != exp_k || o_busy_cnt != exp_busy) begin
                n_fail++; $display("FAIL rnd%0d_timing op=%h got done_k=%0d busy=%0d want %0d %0d",
                                   i, op, o_done_k, o_busy_cnt, exp_k, exp_busy);
            end
            n_tests++;
            if (o_err !== exp_err || o_err_stray != 0 || o_sel_bad != 0) begin
                n_fail++; $display("FAIL rnd%0d_flags op=%h got err=%b stray=%0d selbad=%0d want %b 0 0",
                                   i, op, o_err, o_err_stray, o_sel_bad, exp_err);
            end
            n_tests++;
            if (bus.z_out !== exp_z || bus.hi_out !== exp_hi || bus.lo_out !== exp_lo) begin
                n_fail++; $display("FAIL rnd%0d_result op=%h got z=%h hi=%h lo=%h want %h %h %h",
                                   i, op, bus.z_out, bus.hi_out, bus.lo_out, exp_z, exp_hi, exp_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_start_while_busy();
        test_illegal_back_to_back();
        test_reset_mid_op();
        test_div_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller placed between the control unit and the `alu` datapath. Accepts one operation request at a time through a start/done handshake, latches operands, drives the ALU's one-hot `select`, waits the operation's fixed latency, and captures the result into the Z register or the HI/LO register pair. It gives single-cycle and multi-cycle ALU operations, such as multiply and divide, one uniform interface to the rest of the CPU.

## Interface

- `MUL_CYCLES`, default 2: cycles the ALU needs before `hi`/`lo` are valid for multiply; must be 1 or more.
- `DIV_CYCLES`, default 33: cycles the ALU needs before `hi`/`lo` are valid for divide; must be 1 or more.
- `clk`, input, 1: the only clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `start`, input, 1: request strobe; sampled only while `busy` is 0.
- `opcode`, input, 4: operation index 0x0–0xB. Order: add, sub, shr, shl, ror, rol, and, or, mul, div, neg, not.
- `a_in`, input, 32: operand A, sampled with `start`.
- `b_in`, input, 32: operand B, sampled with `start`.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle completion pulse.
- `err`, output, 1: valid only while `done` is high. It is 1 for an illegal opcode, or for divide-by-zero when enabled.
- `z_out`, output, 32: Z register.
- `hi_out`, output, 32: HI register.
- `lo_out`, output, 32: LO register.
- `alu_a`, output, 32: latched operand A, driven to the ALU.
- `alu_b`, output, 32: latched operand B, driven to the ALU.
- `alu_select`, output, 12: one-hot ALU select; bit n corresponds to opcode n.
- `alu_z`, input, 32: ALU result output.
- `alu_hi`, input, 32: ALU HI output.
- `alu_lo`, input, 32: ALU LO output.

## Operation

- FSM states: IDLE, EXEC.
- **IDLE**
  - `busy`=0 and `alu_select`=0.
  - When `start`=1 with a legal opcode:
    - latch `a_in`, `b_in` and `opcode`;
    - load the latency counter with L−1, where L is 1 for single-cycle ops, `MUL_CYCLES` for mul, `DIV_CYCLES` for div;
    - go to EXEC.
- **EXEC**
  - `busy`=1.
  - `alu_select` is the one-hot of the latched opcode, held stable for the whole state.
  - The counter decrements each cycle. In the cycle the counter is 0:
    - mul/div: capture `alu_hi`/`alu_lo` into `hi_out`/`lo_out`;
    - all other ops: capture `alu_z` into `z_out`.
  - On that same edge: set `done` for the next cycle and return to IDLE.
- **Illegal opcode (0xC–0xF):** with `start` in IDLE, stay in IDLE, pulse `done`=1 and `err`=1 next cycle. No register changes.
- **`start` while `busy`=1:** ignored. Operands and opcode are not re-latched.
- **Result registers:** hold their value until the next completion of the same class. Mul/div never modify Z; other ops never modify HI/LO.
- **`err`:** 0 whenever `done` is 0.

## Timing

- Start sampled on edge N, op latency L:
  - `busy` is high for cycles N+1 … N+L;
  - `done` is high in cycle N+L+1;
  - results are valid from cycle N+L+1.
- Single-cycle ops: `done` two cycles after the `start` edge.
- Back-to-back: `busy` is 0 in the `done` cycle, so a `start` in that cycle is accepted. Throughput is one op per L+1 cycles.
- Reset (`rst_n`=0 at an edge) is honoured in any state, including mid-EXEC. The aborted op produces no `done` and no register update.
- Reset values:
  - state IDLE;
  - `busy`, `done`, `err` = 0;
  - `alu_select` = 0;
  - `alu_a`, `alu_b`, `z_out`, `hi_out`, `lo_out` = 0;
  - counter = 0.

## Configuration

- `ALU_SEQ_DIV0_CHECK_EN`
  - Defined: div with latched `b_in`==0 does not enter EXEC. It pulses `done`=1 and `err`=1 two cycles after the `start` edge; HI/LO are unchanged; `busy` is high for exactly one cycle.
  - Undefined: div by zero runs the full `DIV_CYCLES`, captures whatever the ALU produces, and reports `err`=0.

## Structure

- Shared package `alu_pkg`:
  - opcode localparams `ALU_OP_ADD` … `ALU_OP_NOT` (0x0–0xB);
  - `ALU_SEL_W`=12;
  - function `alu_onehot(opcode)`;
  - function `alu_is_hilo(opcode)`.
  The ALU testbenches use the same package.
- One sub-module, `alu_latency_counter`:
  - loadable down-counter sized from max(`MUL_CYCLES`, `DIV_CYCLES`);
  - ports: `load`, `load_val`, `zero`.
- FSM and result registers live in `alu_sequencer`.

## Test plan

- **Add:** opcode 0x0, a=0x7C, b=0x7.
  - `alu_select`=0x001 during EXEC.
  - `done` two cycles after start.
  - `z_out`=131, `err`=0; HI/LO unchanged.
- **Mul:** opcode 0x8, a=124, b=7, `MUL_CYCLES`=2.
  - `busy` for 2 cycles; `done` 3 cycles after start.
  - `lo_out`=868, `hi_out`=0; `z_out` retains the prior value.
- **Start while busy:** issue div a=100, b=7, then raise `start` with opcode 0x0 during EXEC.
  - The second request is ignored.
  - One `done` after `DIV_CYCLES`+1.
  - `lo_out`/`hi_out` equal the ALU values for 100÷7.
- **Illegal opcode and back-to-back:** opcode 0xD.
  - `done`=1, `err`=1 the next cycle; `busy` never rises.
  - Then a neg with b=7 started in that `done` cycle is accepted, giving `z_out`=0xFFFFFFF9.
- **Reset mid-op:** start div, pull `rst_n` low at EXEC cycle 10.
  - All outputs are 0 after that edge; no `done` appears.
- **Div-by-zero:** with `ALU_SEQ_DIV0_CHECK_EN` defined, div b=0.
  - `done`=1, `err`=1 two cycles after start; HI/LO unchanged.
  - With the macro undefined, the same stimulus gives `done` at `DIV_CYCLES`+1 and `err`=0.
